// File: rtl/led_pkg.sv
// led_pkg: shared sizes, command bytes and parser state type for the LED frame sequencer
package led_pkg;
  localparam int NUM_LEDS = 24;
  localparam int FRAMES = 16;
  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_DWELL = 8'hD7;
  localparam logic [7:0] CMD_START = 8'h5A;
  localparam logic [7:0] CMD_STOP = 8'h55;
  localparam logic [7:0] CMD_BLANK = 8'h3C;
  typedef enum logic [3:0] {P_CMD, P_WI, P_WD0, P_WD1, P_WD2, P_DW0, P_DW1, P_DW2, P_SL} pstate_t;
endpackage

// File: rtl/led_cmd_parser.sv
// led_cmd_parser: byte-stream command decoder producing frame write, dwell and playback strobes
module led_cmd_parser import led_pkg::*; #(
  parameter int LED_W = NUM_LEDS,
  parameter int IDX_W = $clog2(FRAMES),
  parameter int DW_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             acc,
  output logic             wr,
  output logic [IDX_W-1:0] wr_idx,
  output logic [LED_W-1:0] wr_data,
  output logic             dw,
  output logic [DW_W-1:0]  dw_val,
  output logic             start,
  output logic [IDX_W-1:0] start_last,
  output logic             stop,
  output logic             blank,
  output logic             err
);
  pstate_t state, nxt;
  logic [15:0] lo;
  logic [23:0] word;
  logic bad;
  assign word = {rx_data, lo};
  assign wr_data = word[LED_W-1:0];
  assign dw_val = word[DW_W-1:0];
  assign start_last = rx_data[IDX_W-1:0];
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= P_CMD;
      wr_idx <= '0;
      lo <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      err <= bad;
      if (acc && state == P_WI) wr_idx <= rx_data[IDX_W-1:0];
      if (acc && (state == P_WD0 || state == P_DW0)) lo[7:0] <= rx_data;
      if (acc && (state == P_WD1 || state == P_DW1)) lo[15:8] <= rx_data;
    end
  always_comb begin
    nxt = state;
    bad = 1'b0;
    wr = 1'b0;
    dw = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    blank = 1'b0;
    if (acc)
      case (state)
        P_CMD: begin
          nxt = rx_data == CMD_WRITE ? P_WI : rx_data == CMD_DWELL ? P_DW0 : rx_data == CMD_START ? P_SL : P_CMD;
          stop = rx_data == CMD_STOP;
          blank = rx_data == CMD_BLANK;
          bad = !(rx_data inside {CMD_WRITE, CMD_DWELL, CMD_START, CMD_STOP, CMD_BLANK});
        end
        P_WI: begin
          bad = |(rx_data >> IDX_W);
          nxt = bad ? P_CMD : P_WD0;
        end
        P_WD0: nxt = P_WD1;
        P_WD1: nxt = P_WD2;
        P_WD2: begin
          wr = 1'b1;
          nxt = P_CMD;
        end
        P_DW0: nxt = P_DW1;
        P_DW1: nxt = P_DW2;
        P_DW2: begin
          dw = 1'b1;
          nxt = P_CMD;
        end
        P_SL: begin
          start = 1'b1;
          nxt = P_CMD;
        end
        default: nxt = P_CMD;
      endcase
  end
endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: UART-programmed frame memory played out on the LEDs at a programmable dwell
module led_frame_sequencer #(
  parameter int NUM_LEDS = led_pkg::NUM_LEDS,
  parameter int FRAMES = led_pkg::FRAMES,
  parameter int DWELL_W = 24,
  parameter int DWELL_RST = 1200000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [NUM_LEDS-1:0]        leds,
  output logic                       playing,
  output logic [$clog2(FRAMES)-1:0]  frame_idx,
  output logic                       err
);
  localparam int IDX_W = $clog2(FRAMES);
  logic [NUM_LEDS-1:0] mem [FRAMES];
  logic [NUM_LEDS-1:0] wr_data;
  logic [IDX_W-1:0] last, wr_idx, start_last;
  logic [DWELL_W-1:0] dwell, cnt, dw_val;
  logic blanked, wr, dw, start, stop, blank, step;
  led_cmd_parser #(.LED_W(NUM_LEDS), .IDX_W(IDX_W), .DW_W(DWELL_W)) u_parser (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .acc(rx_valid && rx_ready),
    .wr(wr),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .dw(dw),
    .dw_val(dw_val),
    .start(start),
    .start_last(start_last),
    .stop(stop),
    .blank(blank),
    .err(err)
  );
  assign step = playing && cnt == dwell - 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < FRAMES; i++) mem[i] <= '0;
      last <= IDX_W'(FRAMES - 1);
      dwell <= DWELL_W'(DWELL_RST);
      cnt <= '0;
      blanked <= 1'b1;
      playing <= 1'b0;
      frame_idx <= '0;
      leds <= '0;
      rx_ready <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      leds <= blanked ? '0 : mem[frame_idx];
      if (wr) mem[wr_idx] <= wr_data;
      if (dw) dwell <= dw_val | DWELL_W'(dw_val == '0);
      if (start) begin
        last <= start_last;
        playing <= 1'b1;
        blanked <= 1'b0;
        frame_idx <= '0;
        cnt <= '0;
      end else if (stop || blank) begin
        playing <= 1'b0;
        blanked <= blanked | blank;
        cnt <= '0;
      end else if (playing) begin
        cnt <= step ? '0 : cnt + 1'b1;
        if (step) frame_idx <= frame_idx >= last ? '0 : frame_idx + 1'b1;
      end
      if (dw) cnt <= '0;
    end
endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Drives the 24 card LEDs from a 16-entry frame memory, stepping frames at a programmable dwell interval.
- Programmed by a byte stream from the UART receiver (rx path) with commands to write frames, set dwell, start, stop and blank.
- Sits between the UART RX byte interface and the top-level led0..led23 outputs.

Parameters:
- NUM_LEDS, 24, width of one frame and of the led output.
- FRAMES, 16, frame memory depth; a power of two; the index width is log2(FRAMES).
- DWELL_W, 24, dwell counter width in clk cycles.
- DWELL_RST, 1200000, dwell value after reset (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- rx_data  in  8  command/data byte from the UART receiver.
- rx_valid  in  1  rx_data valid; a byte is consumed when rx_valid and rx_ready are both high.
- rx_ready  out  1  byte accept.
- leds  out  NUM_LEDS  LED drive; bit n maps to led n.
- playing  out  1  playback active.
- frame_idx  out  log2(FRAMES)  frame currently selected.
- err  out  1  single-cycle pulse on a protocol error.

Behaviour:
- Reset, sampled on the clk edge while rst_n is low:
  - leds=0, playing=0, frame_idx=0, err=0, rx_ready=0.
  - All frame memory cleared to 0; last=FRAMES-1; dwell=DWELL_RST.
  - Dwell counter=0; blank=1; parser returns to CMD, aborting any partial packet.
- rx_ready=1 in every cycle after reset is released. Bytes are never stalled.
- Parser FSM. It advances only on an accepted byte.
  - CMD, byte 0xA5 -> WI.
  - CMD, byte 0xD7 -> DW0.
  - CMD, byte 0x5A -> SL.
  - CMD, byte 0x55 -> stop: playing=0, frame_idx held, blank unchanged.
  - CMD, byte 0x3C -> playing=0, blank=1.
  - CMD, any other byte -> err pulse, stay in CMD.
  - WI: the byte is the frame index. If the upper bits beyond log2(FRAMES) are non-zero: err pulse, -> CMD, packet dropped. Otherwise latch the index, -> WD0.
  - WD0/WD1/WD2: data bytes, LSB first, into the frame word. The word is written to memory on the edge that accepts the WD2 byte; -> CMD. Bits above NUM_LEDS are ignored.
  - DW0/DW1/DW2: dwell bytes, LSB first. Dwell is updated on the DW2 accept edge, and the dwell counter is zeroed on the same edge. A value of 0 is treated as 1.
  - SL: last = byte[log2(FRAMES)-1:0], upper bits ignored. Then playing=1, blank=0, frame_idx=0, counter=0; -> CMD. A start received while already playing restarts from frame 0.
- Playback:
  - While playing, the counter increments each cycle.
  - When counter == dwell-1: counter=0 and frame_idx = (frame_idx >= last) ? 0 : frame_idx+1.
  - If last is reduced below the current frame_idx, the next step wraps to 0.
  - While not playing, the counter holds at 0.
- LED output:
  - leds is registered: leds <= blank ? 0 : mem[frame_idx], evaluated every cycle.
  - A frame_idx change appears on leds one cycle later.
  - A memory write to the displayed frame appears one cycle after the write edge, whether playing or stopped.
- Simultaneous events: a memory write and a frame step on the same edge are both applied; leds shows the updated data once that frame is selected. A dwell-terminal step and an SL byte on the same edge: SL wins.
- err is high for exactly one cycle per bad byte.

Decomposition:
- Shared package (led_pkg):
  - NUM_LEDS and FRAMES constants.
  - Command byte constants CMD_WRITE=0xA5, CMD_DWELL=0xD7, CMD_START=0x5A, CMD_STOP=0x55, CMD_BLANK=0x3C.
  - Parser state enum.
- One sub-module, led_cmd_parser: the byte FSM, emitting write strobe/index/data, dwell strobe/value, start/stop/blank strobes, and err.
- The top level holds the frame memory, dwell counter and leds register.

Test Plan:
- Reset release -> leds=0, playing=0, rx_ready=1 one cycle later; send 0x3C -> no err, leds stay 0.
- Write frame 0 = 0x00000F (A5 00 0F 00 00), dwell=4 (D7 04 00 00), then 5A 01 -> leds=0x00000F one cycle after the start edge. leds alternates frame 0 / frame 1 (0) every 4 cycles; frame_idx sequence 0,1,0,1.
- While playing frame 1, write frame 1 = 0xFFFFFF -> leds=0xFFFFFF one cycle after the WD2 edge; send 0x55 -> frame_idx frozen and leds held for more than 100 cycles.
- Send byte 0x12 in CMD, then A5 10 -> two single-cycle err pulses; memory unchanged; the following A5 02 01 02 03 writes frame 2 = 0x030201.
- Set dwell=0 (D7 00 00 00), start with last=3 -> frame_idx steps 0,1,2,3,0 on consecutive cycles.
- Assert rst_n=0 for one cycle after only A5 05 03 -> parser returns to CMD; all outputs reset; frame 5 reads 0; playing=0.
